retire_trace_checker: RTL and testbench
=======================================

# retire_trace_checker

Synthesizable lockstep retirement checker comparing two in-order instruction-retirement streams (stream A: pipelined RTL core, stream B: reference/golden core). Each stream is buffered in its own parametrised FIFO so the two producers may retire at different rates. Entries are compared pairwise and in order. The first divergence freezes the block and reports a sticky error code and the retirement index. It sits beside the processor top in simulation and emulation builds, replacing per-cycle testbench polling with an in-fabric checker.

## Interface
- ADDR_W, 32: PC and store-address width.
- DATA_W, 32: register and store-data width.
- DEPTH, 8: per-stream FIFO entries; power of two, ≥2.
- TIMEOUT, 255: cycles one stream may lead with the other FIFO empty; 0 disables.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  checking permitted.
- a_valid, b_valid  in  1  retirement record offered.
- a_ready, b_ready  out  1  record accepted when valid&&ready.
- a_pc, b_pc  in  ADDR_W  PC of retired instruction.
- a_rd_we, b_rd_we  in  1  register write.
- a_rd, b_rd  in  5  destination register.
- a_rd_data, b_rd_data  in  DATA_W  written value.
- a_st, b_st  in  1  instruction is a store.
- a_st_addr, b_st_addr  in  ADDR_W  store address.
- a_st_data, b_st_data  in  DATA_W  store data (byte lanes per be).
- a_st_be, b_st_be  in  DATA_W/8  store byte enables.
- mismatch  out  1  sticky error flag.
- err_code  out  3  0 none, 1 PC, 2 regwrite, 3 store, 4 timeout.
- err_index  out  32  value of retired_cnt when the error was detected.
- retired_cnt  out  32  count of matched pairs.

## Operation
- FSM states:
  - IDLE: reset state; pushes accepted, no pops.
  - CHECK: entered from IDLE when enable=1; returns to IDLE when enable=0, with FIFO contents kept.
  - HALT: entered on any error; exited only by rst.
- Push: each FIFO writes on valid&&ready. ready = !full && state!=HALT. There is no bypass: a full FIFO deasserts ready even in a cycle with a pop.
- Pop: in CHECK, when both FIFOs are non-empty, both heads are popped in the same cycle and latched into a compare register.
- Compare, in priority order:
  - PC differs → code 1.
  - rd_we differs, or (rd_we=1 and rd!=0 and (rd or rd_data differ)) → code 2. A write to r0 is treated as no write.
  - st differs, or (st=1 and (st_addr, st_be, or enabled byte lanes of st_data differ)) → code 3.
- Match: retired_cnt increments by one; wraps modulo 2^32.
- Error: mismatch=1, err_code and err_index are loaded, state→HALT, no further pops. FIFO contents are frozen for debug.
- Timeout: in CHECK, a counter increments each cycle exactly one FIFO is non-empty and the other is empty. It clears otherwise and in IDLE. On reaching TIMEOUT: code 4, HALT.
- A compare error and a timeout in the same cycle: the compare error wins.
- Reset values: a_ready=b_ready=1, mismatch=0, err_code=0, err_index=0, retired_cnt=0. FIFOs are emptied and the timeout counter is cleared. rst mid-operation discards all buffered records.

## Timing
- Record pushed at edge t is poppable in cycle t+1. Compare is registered, so mismatch/retired_cnt update at edge t+2.
- Sustained throughput: one pair per cycle.
- ready is a function of registered state only; there is no combinational valid→ready path.
- Outputs are registered.

## Configuration
- RETIRE_CHECK_STORE_EN defined:
  - store fields are stored in the FIFOs and compared;
  - code 3 is possible.
- RETIRE_CHECK_STORE_EN undefined:
  - st, st_addr, st_data and st_be inputs are ignored and not stored;
  - FIFO width shrinks accordingly;
  - code 3 is never produced.

## Test plan
- Lockstep match: 20 identical records, pushed on both streams on the same cycles with enable=1 → retired_cnt=20, mismatch=0, and the final count is visible 2 cycles after the last push.
- Skewed rates: A pushes 8 records back-to-back while B pushes 1 every 3 cycles → a_ready drops after DEPTH=8 entries fill, no error, retired_cnt=8 at the end.
- Regwrite divergence: the 5th record has a_rd_data=0x1234, b_rd_data=0x1235, rd=7 → mismatch=1, err_code=2, err_index=4, ready=0, retired_cnt remains 4. Same records with rd=0 → no error.
- Store divergence (macro defined): st_be=4'b0011, st_data differs only in byte 3 → no error. st_addr 0x100 vs 0x104 → err_code=3. With macro undefined, the same stimulus → no error.
- Timeout: TIMEOUT=10, A pushes 1 record, B silent → err_code=4 once the counter reaches 10. With PC mismatch pending on the same edge → err_code=1.
- Reset/enable: enable=0 with 3 records per stream → no pops, retired_cnt=0. Setting enable=1 → retired_cnt=3 two cycles later. rst during HALT → all outputs at reset values and FIFOs empty.

Source files
------------

// File: rtl/retire_trace_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : retire_trace_checker (with helper retire_trace_fifo)            |
// | Purpose  : Lockstep checker for two in-order retirement streams. Stream A  |
// |            (core under test) and stream B (reference) are buffered in      |
// |            separate FIFOs, popped pairwise and compared one cycle later.   |
// |            The first divergence, or one stream leading for TIMEOUT cycles, |
// |            freezes the block with a sticky error code and index.           |
// | Ports    : clk, rst (sync, active-high), enable_i                          |
// |            a_*/b_* : valid/ready handshake plus pc, rd_we, rd, rd_data,     |
// |                      st, st_addr, st_data, st_be retirement record        |
// |            mismatch_o, err_code_o[2:0], err_index_o[31:0],                 |
// |            retired_cnt_o[31:0]                                             |
// | Config   : RETIRE_CHECK_STORE_EN -- when defined, store fields are         |
// |            buffered and compared (err_code 3 possible); otherwise they     |
// |            are ignored and the FIFOs are narrower.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

// Simple synchronous FIFO; read data is the current head (no read latency).
module retire_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Storage is not reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
endmodule

module retire_trace_checker #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  // stream A
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [ADDR_W-1:0]   a_pc_i,
  input  logic                a_rd_we_i,
  input  logic [4:0]          a_rd_i,
  input  logic [DATA_W-1:0]   a_rd_data_i,
  input  logic                a_st_i,
  input  logic [ADDR_W-1:0]   a_st_addr_i,
  input  logic [DATA_W-1:0]   a_st_data_i,
  input  logic [DATA_W/8-1:0] a_st_be_i,
  // stream B
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [ADDR_W-1:0]   b_pc_i,
  input  logic                b_rd_we_i,
  input  logic [4:0]          b_rd_i,
  input  logic [DATA_W-1:0]   b_rd_data_i,
  input  logic                b_st_i,
  input  logic [ADDR_W-1:0]   b_st_addr_i,
  input  logic [DATA_W-1:0]   b_st_data_i,
  input  logic [DATA_W/8-1:0] b_st_be_i,
  // status
  output logic                mismatch_o,
  output logic [2:0]          err_code_o,
  output logic [31:0]         err_index_o,
  output logic [31:0]         retired_cnt_o
);
  // Record layout (LSB first): pc | rd_we | rd | rd_data [| st | st_addr | st_data | st_be]
  localparam int BE_W    = DATA_W / 8;
  localparam int WE_BIT  = ADDR_W;
  localparam int RD_LSB  = ADDR_W + 1;
  localparam int RDD_LSB = ADDR_W + 6;
  localparam int BASE_W  = ADDR_W + 6 + DATA_W;
`ifdef RETIRE_CHECK_STORE_EN
  localparam int ST_BIT  = BASE_W;
  localparam int STA_LSB = BASE_W + 1;
  localparam int STD_LSB = STA_LSB + ADDR_W;
  localparam int BE_LSB  = STD_LSB + DATA_W;
  localparam int REC_W   = BE_LSB + BE_W;
`else
  localparam int REC_W   = BASE_W;
`endif

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_PC    = 3'd1;
  localparam logic [2:0] ERR_REG   = 3'd2;
  localparam logic [2:0] ERR_STORE = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [REC_W-1:0]  a_rec, b_rec, a_head, b_head;
  logic [REC_W-1:0]  a_cmp_q, b_cmp_q;
  logic              cmp_valid_q;
  logic              a_push, b_push, a_empty, b_empty, a_full, b_full;
  logic              pop;
  logic [31:0]       tmo_q, tmo_d;
  logic              imbal, tmo_fire;
  logic              pc_err, rd_err, st_err;
  logic              a_we_eff, b_we_eff;
  logic [2:0]        cmp_code, err_code_d;
  logic              mismatch_q;
  logic [2:0]        err_code_q;
  logic [31:0]       err_index_q, retired_cnt_q;

`ifdef RETIRE_CHECK_STORE_EN
  assign a_rec = {a_st_be_i, a_st_data_i, a_st_addr_i, a_st_i, a_rd_data_i, a_rd_i, a_rd_we_i, a_pc_i};
  assign b_rec = {b_st_be_i, b_st_data_i, b_st_addr_i, b_st_i, b_rd_data_i, b_rd_i, b_rd_we_i, b_pc_i};
`else
  assign a_rec = {a_rd_data_i, a_rd_i, a_rd_we_i, a_pc_i};
  assign b_rec = {b_rd_data_i, b_rd_i, b_rd_we_i, b_pc_i};
  // Store inputs are intentionally dropped in this build.
  logic w_st_unused;
  assign w_st_unused = ^{a_st_i, a_st_addr_i, a_st_data_i, a_st_be_i,
                         b_st_i, b_st_addr_i, b_st_data_i, b_st_be_i};
`endif

  // Ready depends only on registered occupancy and state, never on valid.
  assign a_ready_o = !a_full && (state_q != S_HALT);
  assign b_ready_o = !b_full && (state_q != S_HALT);
  assign a_push    = a_valid_i && a_ready_o;
  assign b_push    = b_valid_i && b_ready_o;

  retire_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push_i(a_push), .data_i(a_rec), .pop_i(pop),
    .data_o(a_head), .empty_o(a_empty), .full_o(a_full)
  );

  retire_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push_i(b_push), .data_i(b_rec), .pop_i(pop),
    .data_o(b_head), .empty_o(b_empty), .full_o(b_full)
  );

  // ---------------------------------------------------------------------------
  // Pairwise compare of the latched heads. A write to r0 counts as no write.
  // ---------------------------------------------------------------------------
  assign pc_err   = a_cmp_q[ADDR_W-1:0] != b_cmp_q[ADDR_W-1:0];
  assign a_we_eff = a_cmp_q[WE_BIT] && (a_cmp_q[RD_LSB +: 5] != 5'd0);
  assign b_we_eff = b_cmp_q[WE_BIT] && (b_cmp_q[RD_LSB +: 5] != 5'd0);
  assign rd_err   = (a_we_eff != b_we_eff) ||
                    (a_we_eff && ((a_cmp_q[RD_LSB +: 5] != b_cmp_q[RD_LSB +: 5]) ||
                                  (a_cmp_q[RDD_LSB +: DATA_W] != b_cmp_q[RDD_LSB +: DATA_W])));

`ifdef RETIRE_CHECK_STORE_EN
  logic [DATA_W-1:0] lane_mask;
  // Only bytes enabled by A's strobes are compared; a strobe mismatch is
  // already an error on its own.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign lane_mask[8*gi +: 8] = {8{a_cmp_q[BE_LSB + gi]}};
  end
  assign st_err = (a_cmp_q[ST_BIT] != b_cmp_q[ST_BIT]) ||
                  (a_cmp_q[ST_BIT] &&
                   ((a_cmp_q[STA_LSB +: ADDR_W] != b_cmp_q[STA_LSB +: ADDR_W]) ||
                    (a_cmp_q[BE_LSB +: BE_W]    != b_cmp_q[BE_LSB +: BE_W]) ||
                    (((a_cmp_q[STD_LSB +: DATA_W] ^ b_cmp_q[STD_LSB +: DATA_W]) & lane_mask) != '0)));
`else
  assign st_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / error selection
  // ---------------------------------------------------------------------------
  assign imbal    = (state_q == S_CHECK) && (a_empty != b_empty);
  assign tmo_fire = (TIMEOUT != 0) && imbal && (tmo_q == 32'(TIMEOUT - 1));

  always_comb begin
    cmp_code   = ERR_NONE;
    err_code_d = ERR_NONE;
    state_d    = state_q;
    tmo_d      = 32'd0;
    pop        = 1'b0;

    if (cmp_valid_q) begin
      if (pc_err)      cmp_code = ERR_PC;
      else if (rd_err) cmp_code = ERR_REG;
      else if (st_err) cmp_code = ERR_STORE;
    end

    // A compare error outranks a timeout on the same edge.
    if (cmp_code != ERR_NONE) err_code_d = cmp_code;
    else if (tmo_fire)        err_code_d = ERR_TMO;

    if (imbal) tmo_d = tmo_q + 32'd1;

    // No pop while an error is being reported, so the FIFOs stay frozen.
    pop = (state_q == S_CHECK) && !a_empty && !b_empty && (cmp_code == ERR_NONE);

    case (state_q)
      S_IDLE:  if (enable_i)  state_d = S_CHECK;
      S_CHECK: if (!enable_i) state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (err_code_d != ERR_NONE) state_d = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmp_valid_q   <= 1'b0;
      tmo_q         <= 32'd0;
      mismatch_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_index_q   <= 32'd0;
      retired_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmp_valid_q <= pop;
      tmo_q       <= tmo_d;
      if (err_code_d != ERR_NONE) begin
        mismatch_q  <= 1'b1;
        err_code_q  <= err_code_d;
        err_index_q <= retired_cnt_q;
      end else if (cmp_valid_q) begin
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
    end
  end

  // Compare register: datapath only, qualified by cmp_valid_q.
  always_ff @(posedge clk) begin
    if (pop) begin
      a_cmp_q <= a_head;
      b_cmp_q <= b_head;
    end
  end

  assign mismatch_o    = mismatch_q;
  assign err_code_o    = err_code_q;
  assign err_index_o   = err_index_q;
  assign retired_cnt_o = retired_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_retire_trace_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_retire_trace_checker                                         |
// | Purpose  : Directed self-checking bench for retire_trace_checker. Expected |
// |            retirement counts are queued as matching pairs are driven and   |
// |            popped whenever the DUT's retired count advances.               |
// |            Honours RETIRE_CHECK_STORE_EN for the store-compare case.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_retire_trace_checker;
`ifdef RETIRE_CHECK_STORE_EN
  localparam bit STORE_EN = 1'b1;
`else
  localparam bit STORE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        st;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic        a_valid, b_valid, a_ready, b_ready, a_ready1, b_ready1;
  rec_t        ra_drv, rb_drv;
  logic        mismatch, mismatch1;
  logic [2:0]  err_code, err_code1;
  logic [31:0] err_index, err_index1, retired, retired1;

  int          total = 0;
  int          bad   = 0;
  int          exp_q[$];
  int          model_cnt;
  logic [31:0] last_cnt;

  always #5 clk = ~clk;

  retire_trace_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .enable_i(enable),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_pc_i(ra_drv.pc), .a_rd_we_i(ra_drv.we),
    .a_rd_i(ra_drv.rd), .a_rd_data_i(ra_drv.rd_data), .a_st_i(ra_drv.st),
    .a_st_addr_i(ra_drv.st_addr), .a_st_data_i(ra_drv.st_data), .a_st_be_i(ra_drv.st_be),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_pc_i(rb_drv.pc), .b_rd_we_i(rb_drv.we),
    .b_rd_i(rb_drv.rd), .b_rd_data_i(rb_drv.rd_data), .b_st_i(rb_drv.st),
    .b_st_addr_i(rb_drv.st_addr), .b_st_data_i(rb_drv.st_data), .b_st_be_i(rb_drv.st_be),
    .mismatch_o(mismatch), .err_code_o(err_code), .err_index_o(err_index),
    .retired_cnt_o(retired)
  );

  // Second instance with TIMEOUT=1 so a timeout can coincide with a compare error.
  retire_trace_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT(1)) dut1 (
    .clk(clk), .rst(rst), .enable_i(enable),
    .a_valid_i(a_valid), .a_ready_o(a_ready1), .a_pc_i(ra_drv.pc), .a_rd_we_i(ra_drv.we),
    .a_rd_i(ra_drv.rd), .a_rd_data_i(ra_drv.rd_data), .a_st_i(ra_drv.st),
    .a_st_addr_i(ra_drv.st_addr), .a_st_data_i(ra_drv.st_data), .a_st_be_i(ra_drv.st_be),
    .b_valid_i(b_valid), .b_ready_o(b_ready1), .b_pc_i(rb_drv.pc), .b_rd_we_i(rb_drv.we),
    .b_rd_i(rb_drv.rd), .b_rd_data_i(rb_drv.rd_data), .b_st_i(rb_drv.st),
    .b_st_addr_i(rb_drv.st_addr), .b_st_data_i(rb_drv.st_data), .b_st_be_i(rb_drv.st_be),
    .mismatch_o(mismatch1), .err_code_o(err_code1), .err_index_o(err_index1),
    .retired_cnt_o(retired1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t mk(input int i);
    rec_t r;
    r.pc      = 32'h1000 + 32'(i * 4);
    r.we      = 1'b1;
    r.rd      = 5'((i % 31) + 1);
    r.rd_data = (32'(i) * 32'h0101_0101) ^ 32'h0000_dead;
    r.st      = (i % 3 == 0);
    r.st_addr = 32'h2000 + 32'(i * 4);
    r.st_data = ~r.rd_data;
    r.st_be   = 4'hf;
    return r;
  endfunction

  task automatic set_a(input rec_t r); a_valid = 1'b1; ra_drv = r; endtask
  task automatic set_b(input rec_t r); b_valid = 1'b1; rb_drv = r; endtask
  task automatic clr_a(); a_valid = 1'b0; endtask
  task automatic clr_b(); b_valid = 1'b0; endtask

  task automatic expect_match();
    model_cnt++;
    exp_q.push_back(model_cnt);
  endtask

  // Advance one clock, sample 1 time unit after the edge, run the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst && (retired !== last_cnt)) begin
      if (exp_q.size() == 0) chk("sb_unexpected_retire", retired, last_cnt);
      else                   chk("sb_retire", retired, 32'(exp_q.pop_front()));
      last_cnt = retired;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; clr_a(); clr_b();
    step(); step();
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    last_cnt  = 32'd0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t ra, rb;
    int   bi;
    logic [2:0] exp_err;
    ra_drv = mk(0); rb_drv = mk(0);
    a_valid = 1'b0; b_valid = 1'b0; enable = 1'b0; rst = 1'b1;

    // ---- reset state
    do_reset();
    chk("rst_ready", 32'({a_ready, b_ready}), 32'h3);
    chk("rst_mismatch", 32'(mismatch), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_index", err_index, 0);
    chk("rst_cnt", retired, 0);

    // ---- lockstep: 20 identical records
    enable = 1'b1; step();
    for (int i = 0; i < 20; i++) begin
      set_a(mk(i)); set_b(mk(i)); expect_match();
      step();
      chk("ls_ready", 32'({a_ready, b_ready}), 32'h3);
    end
    clr_a(); clr_b();
    step(); chk("ls_cnt_plus1", retired, 19);
    step(); chk("ls_cnt_plus2", retired, 20);
    chk("ls_mismatch", 32'(mismatch), 0);
    chk("ls_sb_drained", 32'(exp_q.size()), 0);

    // ---- skewed rates: A fills its FIFO while B trickles in
    do_reset();
    for (int k = 0; k < 8; k++) expect_match();
    bi = 0;
    for (int c = 0; c < 8; c++) begin
      set_a(mk(c));
      if (c % 3 == 0) begin set_b(mk(bi)); bi++; end else clr_b();
      step();
    end
    clr_a(); clr_b();
    chk("sk_a_full_ready", 32'(a_ready), 0);
    chk("sk_b_ready", 32'(b_ready), 1);
    enable = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if ((c % 3 == 0) && (bi < 8)) begin set_b(mk(bi)); bi++; end else clr_b();
      step();
    end
    clr_b(); step(); step(); step();
    chk("sk_cnt", retired, 8);
    chk("sk_mismatch", 32'(mismatch), 0);
    chk("sk_a_ready_back", 32'(a_ready), 1);
    chk("sk_sb_drained", 32'(exp_q.size()), 0);

    // ---- regwrite divergence on record 5; repeated with rd=0 (no write)
    for (int v = 0; v < 2; v++) begin
      do_reset();
      enable = 1'b1; step();
      for (int i = 0; i < 5; i++) begin
        ra = mk(i); rb = mk(i);
        if (i == 4) begin
          ra.rd = (v == 0) ? 5'd7 : 5'd0; rb.rd = ra.rd;
          ra.rd_data = 32'h1234; rb.rd_data = 32'h1235;
          if (v == 1) expect_match();
        end else begin
          expect_match();
        end
        set_a(ra); set_b(rb); step();
      end
      clr_a(); clr_b();
      step();
      chk("rw_no_err_yet", 32'(mismatch), 0);
      step();
      if (v == 0) begin
        chk("rw_mismatch", 32'(mismatch), 1);
        chk("rw_code", 32'(err_code), 2);
        chk("rw_index", err_index, 4);
        chk("rw_ready", 32'({a_ready, b_ready}), 0);
        step(); step();
        chk("rw_cnt_held", retired, 4);
      end else begin
        chk("r0_mismatch", 32'(mismatch), 0);
        chk("r0_cnt", retired, 5);
      end
      chk("rw_sb_drained", 32'(exp_q.size()), 0);
    end

    // ---- store compare: masked byte lane, then differing address
    for (int v = 0; v < 2; v++) begin
      do_reset();
      enable = 1'b1; step();
      ra = mk(0); rb = mk(0);
      ra.st = 1'b1; rb.st = 1'b1;
      ra.st_be = 4'b0011; rb.st_be = 4'b0011;
      ra.st_data = 32'h1122_3344;
      rb.st_data = (v == 0) ? 32'hAA22_3344 : 32'h1122_3344;
      ra.st_addr = 32'h100;
      rb.st_addr = (v == 0) ? 32'h100 : 32'h104;
      exp_err = ((v == 1) && STORE_EN) ? 3'd3 : 3'd0;
      if (exp_err == 3'd0) expect_match();
      set_a(ra); set_b(rb); step();
      clr_a(); clr_b(); step(); step(); step();
      chk("st_code", 32'(err_code), 32'(exp_err));
      chk("st_cnt", retired, (exp_err == 3'd0) ? 32'd1 : 32'd0);
    end

    // ---- timeout: A leads by one record, B silent
    do_reset();
    enable = 1'b1; step();
    set_a(mk(0)); step(); clr_a();
    for (int k = 0; k < 9; k++) step();
    chk("tmo_not_yet", 32'(mismatch), 0);
    step();
    chk("tmo_code", 32'(err_code), 4);
    chk("tmo_mismatch", 32'(mismatch), 1);
    chk("tmo_index", err_index, 0);

    // ---- compare error and timeout on the same edge (TIMEOUT=1 instance)
    do_reset();
    enable = 1'b1; step();
    ra = mk(0); rb = mk(0); rb.pc = rb.pc + 32'd4;
    set_a(ra); set_b(rb); step();
    set_a(mk(1)); clr_b(); step();
    clr_a(); step();
    chk("prio_code", 32'(err_code1), 1);
    chk("prio_mismatch", 32'(mismatch1), 1);
    chk("prio_index", err_index1, 0);
    chk("prio_ready", 32'({a_ready1, b_ready1}), 0);
    chk("prio_cnt", retired1, 0);

    // ---- enable gating, then reset out of HALT
    do_reset();
    for (int k = 0; k < 3; k++) expect_match();
    for (int i = 0; i < 3; i++) begin set_a(mk(i)); set_b(mk(i)); step(); end
    clr_a(); clr_b(); step(); step(); step();
    chk("en_off_cnt", retired, 0);
    chk("en_off_ready", 32'({a_ready, b_ready}), 32'h3);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("en_on_cnt", retired, 3);
    ra = mk(3); rb = mk(3); rb.pc = 32'hdead_0000;
    set_a(ra); set_b(rb); step();
    set_a(mk(4)); set_b(mk(4)); step();
    set_a(mk(5)); set_b(mk(5)); step();
    clr_a(); clr_b(); step();
    chk("halt_code", 32'(err_code), 1);
    chk("halt_index", err_index, 3);
    rst = 1'b1; step(); rst = 1'b0;
    exp_q.delete(); model_cnt = 0; last_cnt = 32'd0;
    chk("hrst_ready", 32'({a_ready, b_ready}), 32'h3);
    chk("hrst_mismatch", 32'(mismatch), 0);
    chk("hrst_code", 32'(err_code), 0);
    chk("hrst_index", err_index, 0);
    chk("hrst_cnt", retired, 0);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("hrst_fifo_empty_cnt", retired, 0);
    chk("hrst_fifo_empty_mm", 32'(mismatch), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
